// File: rtl/bcd_conv_sched.sv
// Round-robin front end that multiplexes four requesters onto one shared binary-to-BCD
// converter and returns the result (or a timeout/digit error) tagged with the requester id.
//
// Handshakes: a requester holds req[i] until it sees the one-cycle gnt[i] pulse, which
// means its byte has been captured. conv_start is a one-cycle strobe and conv_value stays
// stable until the converter answers with a one-cycle conv_done. rsp_valid is a one-cycle
// strobe that qualifies rsp_id/rsp_bcd/rsp_err, and those fields hold until the next response.
module bcd_conv_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [8*NREQ-1:0]    req_data,
  output logic [NREQ-1:0]      gnt,
  output logic                 conv_start,
  output logic [7:0]           conv_value,
  input  logic                 conv_done,
  input  logic [3:0]           conv_one,
  input  logic [3:0]           conv_ten,
  input  logic [1:0]           conv_hun,
  output logic                 rsp_valid,
  output logic [1:0]           rsp_id,
  output logic [9:0]           rsp_bcd,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t          state, next_state;
  logic [1:0]      last_grant;
  logic [1:0]      win_idx;
  logic            win_found;
  logic [CW-1:0]   cnt;
  logic            timeout_hit;

  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));
  assign busy        = (state != IDLE);

  // Search upward from the requester after the last winner; i = 4 wraps back to it.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_grant;
    for (int i = 1; i <= 4; i++) begin
      if (!win_found && req[2'(last_grant + 2'(i))]) begin
        win_found = 1'b1;
        win_idx   = 2'(last_grant + 2'(i));
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (win_found) next_state = START;
      START:   next_state = WAIT;
      WAIT:    if (conv_done || timeout_hit) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // last_grant doubles as the latched index of the transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 2'd3;
      cnt        <= '0;
      gnt        <= '0;
      conv_start <= 1'b0;
      conv_value <= 8'd0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 2'd0;
      rsp_bcd    <= 10'd0;
      rsp_err    <= 1'b0;
    end else begin
      gnt        <= '0;
      conv_start <= 1'b0;
      rsp_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            gnt[win_idx] <= 1'b1;
            last_grant   <= win_idx;
            conv_value   <= req_data[{win_idx, 3'b000} +: 8];
          end
        end
        START: begin
          conv_start <= 1'b1;
          cnt        <= '0;
        end
        WAIT: begin
          if (conv_done) begin
            rsp_valid <= 1'b1;
            rsp_id    <= last_grant;
            rsp_bcd   <= {conv_hun, conv_ten, conv_one};
            rsp_err   <= (conv_one > 4'd9) || (conv_ten > 4'd9);
          end else if (timeout_hit) begin
            rsp_valid <= 1'b1;
            rsp_id    <= last_grant;
            rsp_bcd   <= 10'd0;
            rsp_err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Self-checking bench for bcd_conv_sched: the bench plays the converter, predicts each
// response from the granted byte and checks it against a scoreboard queue.
module tb_bcd_conv_sched;

  localparam int TIMEOUT = 16;
  localparam int W       = 13;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        conv_start;
  logic [7:0]  conv_value;
  logic        conv_done;
  logic [3:0]  conv_one;
  logic [3:0]  conv_ten;
  logic [1:0]  conv_hun;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [9:0]  rsp_bcd;
  logic        rsp_err;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  bcd_conv_sched #(.NREQ(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .conv_start(conv_start), .conv_value(conv_value), .conv_done(conv_done),
    .conv_one(conv_one), .conv_ten(conv_ten), .conv_hun(conv_hun),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_bcd(rsp_bcd), .rsp_err(rsp_err),
    .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [9:0] bcd_of(input logic [7:0] v);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    return {2'(h), 4'(t), 4'(o)};
  endfunction

  function automatic logic [27:0] out_vec();
    return {gnt, conv_start, conv_value, rsp_valid, rsp_id, rsp_bcd, rsp_err, busy};
  endfunction

  // One full transaction; mode 0 = normal, 1 = converter silent, 2 = tens digit 0xA.
  task automatic do_txn(input logic [1:0] id, input logic [7:0] val, input int delay,
                        input int mode, input bit drop);
    logic [3:0]   exp_gnt;
    logic [9:0]   bcd;
    logic [W-1:0] exp, got;
    int k;
    exp_gnt = 4'b0001 << id;
    bcd     = bcd_of(val);
    k = 0;
    do begin tick(); k++; end while (gnt === 4'b0000 && k < 20);
    n_tests++;
    if (gnt !== exp_gnt) begin
      n_fail++;
      $display("FAIL gnt: got %b expected %b", gnt, exp_gnt);
      return;
    end
    if (drop) req[id] = 1'b0;
    case (mode)
      1:       exp = {id, 1'b1, 10'd0};
      2:       exp = {id, 1'b1, bcd[9:8], 4'hA, bcd[3:0]};
      default: exp = {id, 1'b0, bcd};
    endcase
    exp_q.push_back(exp);
    tick();
    n_tests++;
    if ({conv_start, conv_value, gnt} !== {1'b1, val, 4'b0000}) begin
      n_fail++;
      $display("FAIL conv_start: got start=%b value=%0d gnt=%b expected start=1 value=%0d gnt=0000",
               conv_start, conv_value, gnt, val);
    end
    tick();
    n_tests++;
    if (conv_start !== 1'b0) begin
      n_fail++;
      $display("FAIL conv_start_pulse: got %b expected 0", conv_start);
    end
    if (mode == 1) begin
      k = 1;
      while (rsp_valid !== 1'b1 && k < TIMEOUT + 5) begin tick(); k++; end
      n_tests++;
      if (k != TIMEOUT) begin
        n_fail++;
        $display("FAIL timeout_latency: got %0d expected %0d", k, TIMEOUT);
      end
    end else begin
      repeat (delay - 1) tick();
      conv_hun  = bcd[9:8];
      conv_ten  = (mode == 2) ? 4'hA : bcd[7:4];
      conv_one  = bcd[3:0];
      conv_done = 1'b1;
      tick();
      conv_done = 1'b0;
      conv_hun  = 2'($urandom);
      conv_ten  = 4'($urandom);
      conv_one  = 4'($urandom);
      k = 0;
      while (rsp_valid !== 1'b1 && k < 20) begin tick(); k++; end
      n_tests++;
      if (k != 0) begin
        n_fail++;
        $display("FAIL rsp_latency: got %0d extra cycles expected 0", k);
      end
    end
    n_tests++;
    if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL rsp_missing: got rsp_valid=%b queued=%0d expected rsp_valid=1",
               rsp_valid, exp_q.size());
    end else begin
      exp = exp_q.pop_front();
      got = {rsp_id, rsp_err, rsp_bcd};
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rsp_fields: got id=%0d err=%b bcd=%b expected id=%0d err=%b bcd=%b",
                 got[12:11], got[10], got[9:0], exp[12:11], exp[10], exp[9:0]);
      end
    end
    tick();
    n_tests++;
    if ({rsp_valid, busy, rsp_id, rsp_err, rsp_bcd} !== {2'b00, exp}) begin
      n_fail++;
      $display("FAIL rsp_hold: got valid=%b busy=%b id=%0d err=%b bcd=%b expected valid=0 busy=0 id=%0d err=%b bcd=%b",
               rsp_valid, busy, rsp_id, rsp_err, rsp_bcd, exp[12:11], exp[10], exp[9:0]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b0; req_data = 32'd0;
    conv_done = 1'b0; conv_one = 4'd0; conv_ten = 4'd0; conv_hun = 2'd0;
    tick(); tick();
    n_tests++;
    if (out_vec() !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0000000", out_vec());
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] ids [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] vals[4] = '{8'd5, 8'd47, 8'd99, 8'd200};
    req_data = {vals[3], vals[2], vals[1], vals[0]};
    rst_n = 1'b1;
    req   = 4'b1111;
    for (int i = 0; i < 5; i++)
      do_txn(ids[i], vals[ids[i]], $urandom_range(1, 4), 0, 1'b0);
    req = 4'b0000;
  endtask

  task automatic test_basic();
    req_data = 32'd173;
    req      = 4'b0001;
    do_txn(2'd0, 8'd173, 9, 0, 1'b1);
    n_tests++;
    if (rsp_bcd !== 10'b01_0111_0011) begin
      n_fail++;
      $display("FAIL bcd_173: got %b expected 0101110011", rsp_bcd);
    end
  endtask

  task automatic test_timeout();
    req_data = 32'h0096_0000;
    req      = 4'b0100;
    do_txn(2'd2, 8'd150, 1, 1, 1'b1);
  endtask

  task automatic test_done_in_idle();
    conv_hun = 2'd2; conv_ten = 4'd9; conv_one = 4'd9;
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    tick();
    n_tests++;
    if (out_vec() !== {4'b0, 1'b0, 8'd150, 1'b0, 2'd2, 10'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL done_in_idle: got %h expected %h", out_vec(),
               {4'b0, 1'b0, 8'd150, 1'b0, 2'd2, 10'd0, 1'b1, 1'b0});
    end
    req_data = {8'd42, 24'd0};
    req      = 4'b1000;
    do_txn(2'd3, 8'd42, 3, 2, 1'b1);
  endtask

  task automatic test_reset_in_wait();
    int seen;
    req_data = 32'd200;
    req      = 4'b0001;
    tick();
    n_tests++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL pre_reset_gnt: got %b expected 0001", gnt);
    end
    req = 4'b0000;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_vec() !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_in_wait: got %h expected 0000000", out_vec());
    end
    seen = 0;
    repeat (3) begin tick(); if (rsp_valid !== 1'b0) seen++; end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_no_rsp: got %0d responses expected 0", seen);
    end
    rst_n    = 1'b1;
    req_data = {8'd0, 8'd255, 8'd0, 8'd0};
    req      = 4'b0110;
    do_txn(2'd1, 8'd0, 2, 0, 1'b1);
    n_tests++;
    if (rsp_bcd !== 10'd0) begin
      n_fail++;
      $display("FAIL bcd_0: got %b expected 0000000000", rsp_bcd);
    end
  endtask

  task automatic test_boundary_255();
    do_txn(2'd2, 8'd255, 5, 0, 1'b1);
    n_tests++;
    if (rsp_bcd !== 10'b10_0101_0101) begin
      n_fail++;
      $display("FAIL bcd_255: got %b expected 1001010101", rsp_bcd);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_basic();
    test_timeout();
    test_done_in_idle();
    test_reset_in_wait();
    test_boundary_255();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
